// File: rtl/fir_tap_window.sv
// Sample delay line and coefficient bank manager feeding a parallel FIR MAC.
// Presents a window of N_TAPS samples (newest first) with a committed coefficient bank.
module fir_tap_window #(
   parameter int N_TAPS      = 16,
   parameter int IN_WIDTH    = 12,
   parameter int COEFF_WIDTH = 16,
   parameter int PRIME_FULL  = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic signed [IN_WIDTH-1:0]      s_data,
   input  logic                            coef_wr_en,
   input  logic [$clog2(N_TAPS)-1:0]       coef_wr_addr,
   input  logic [COEFF_WIDTH-1:0]          coef_wr_data,
   input  logic                            coef_commit,
   output logic                            coef_busy,
   input  logic                            flush,
   output logic                            win_valid,
   output logic [N_TAPS*IN_WIDTH-1:0]      win_samples,
   output logic [N_TAPS*COEFF_WIDTH-1:0]   win_coeffs,
   output logic [$clog2(N_TAPS):0]         fill_count
);

   localparam int CW = $clog2(N_TAPS) + 1;

   typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH} state_e;

   state_e                         state_q, state_d;
   logic signed [IN_WIDTH-1:0]     slot_q   [N_TAPS];
   logic signed [IN_WIDTH-1:0]     slot_d   [N_TAPS];
   logic [COEFF_WIDTH-1:0]         shadow_q [N_TAPS];
   logic [COEFF_WIDTH-1:0]         shadow_d [N_TAPS];
   logic [COEFF_WIDTH-1:0]         active_q [N_TAPS];
   logic [COEFF_WIDTH-1:0]         active_d [N_TAPS];
   logic [CW-1:0]                  fill_count_q, fill_count_d;
   logic                           win_valid_q, win_valid_d;
   logic                           coef_busy_q, coef_busy_d;
   logic                           accept;
   logic                           clear_line;

   // ---------------- state register ----------------
   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // blocking = is reserved for the always_comb next-state logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_FILL:  if (accept && fill_count_q == CW'(N_TAPS - 1)) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_FLUSH: state_d = ST_FILL;
            default:  state_d = ST_FILL;
         endcase
      end
   end

   // ---------------- output logic ----------------
   // s_ready drops combinationally with rst and flush so a colliding sample is refused.
   always_comb begin
      s_ready = !rst && (state_q != ST_FLUSH) && !flush;
   end

   assign accept     = s_valid && s_ready;
   assign clear_line = flush || (state_q == ST_FLUSH);

   // ---------------- delay line and window strobe ----------------
   always_comb begin
      slot_d       = slot_q;
      fill_count_d = fill_count_q;
      if (clear_line) begin
         for (int i = 0; i < N_TAPS; i++) slot_d[i] = '0;
         fill_count_d = '0;
      end else if (accept) begin
         slot_d[0] = s_data;
         for (int i = 1; i < N_TAPS; i++) slot_d[i] = slot_q[i-1];
         if (fill_count_q != CW'(N_TAPS)) fill_count_d = fill_count_q + CW'(1);
      end
   end

   // The strobe fires on every accept except while priming an incomplete window.
   always_comb begin
      win_valid_d = accept && ((state_q == ST_RUN) || (PRIME_FULL == 0) ||
                               (fill_count_q == CW'(N_TAPS - 1)));
   end

   // ---------------- coefficient banks ----------------
   // The active bank only swaps on a cycle without an accept, so a window never
   // pairs with a half-updated bank.
   always_comb begin
      shadow_d    = shadow_q;
      active_d    = active_q;
      coef_busy_d = coef_busy_q;
      if (coef_wr_en && !coef_busy_q) shadow_d[coef_wr_addr] = coef_wr_data;
      if (coef_busy_q) begin
         if (!accept) begin
            active_d    = shadow_q;
            coef_busy_d = 1'b0;
         end
      end else if (coef_commit) begin
         coef_busy_d = 1'b1;
      end
   end

   // NOTE: the coefficient banks are small register files that must read 0 after
   // reset, so they are reset like any other flop rather than left as RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_TAPS; i++) begin
            slot_q[i]   <= '0;
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         fill_count_q <= '0;
         win_valid_q  <= 1'b0;
         coef_busy_q  <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         fill_count_q <= fill_count_d;
         win_valid_q  <= win_valid_d;
         coef_busy_q  <= coef_busy_d;
      end
   end

   // ---------------- output packing (slot 0 in the top field) ----------------
   always_comb begin
      win_samples = '0;
      win_coeffs  = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         win_samples[(N_TAPS-i)*IN_WIDTH-1 -: IN_WIDTH]    = slot_q[i];
         win_coeffs[(N_TAPS-i)*COEFF_WIDTH-1 -: COEFF_WIDTH] = active_q[i];
      end
   end

   assign win_valid  = win_valid_q;
   assign coef_busy  = coef_busy_q;
   assign fill_count = fill_count_q;

endmodule

// File: tb/tb_fir_tap_window.sv
// Directed bench for fir_tap_window (N_TAPS=16, IN_WIDTH=12, COEFF_WIDTH=16, PRIME_FULL=1).
module tb_fir_tap_window;

   localparam int N   = 16;
   localparam int IW  = 12;
   localparam int CWD = 16;

   logic                    clk;
   logic                    rst;
   logic                    s_valid;
   logic                    s_ready;
   logic signed [IW-1:0]    s_data;
   logic                    coef_wr_en;
   logic [3:0]              coef_wr_addr;
   logic [CWD-1:0]          coef_wr_data;
   logic                    coef_commit;
   logic                    coef_busy;
   logic                    flush;
   logic                    win_valid;
   logic [N*IW-1:0]         win_samples;
   logic [N*CWD-1:0]        win_coeffs;
   logic [4:0]              fill_count;

   int total;
   int bad;

   fir_tap_window #(.N_TAPS(N), .IN_WIDTH(IW), .COEFF_WIDTH(CWD), .PRIME_FULL(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data),
      .coef_commit  (coef_commit),
      .coef_busy    (coef_busy),
      .flush        (flush),
      .win_valid    (win_valid),
      .win_samples  (win_samples),
      .win_coeffs   (win_coeffs),
      .fill_count   (fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IW-1:0] slot(input int i);
      return win_samples[(N-i)*IW-1 -: IW];
   endfunction

   function automatic logic [CWD-1:0] coeff(input int i);
      return win_coeffs[(N-i)*CWD-1 -: CWD];
   endfunction

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int v);
      s_valid = 1'b1;
      s_data  = IW'(v);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %0b want 0", s_ready); end
      total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %0b want 0", win_valid); end
      total++; if (coef_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", coef_busy); end
      total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
      total++; if (win_samples !== '0) begin bad++; $display("FAIL reset_samples: got %h want 0", win_samples); end
      total++; if (win_coeffs !== '0) begin bad++; $display("FAIL reset_coeffs: got %h want 0", win_coeffs); end
      rst = 1'b0;
      #1;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %0b want 1", s_ready); end
   endtask

   task automatic test_prime();
      for (int i = 1; i <= 15; i++) begin
         feed(i);
         total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL prime_early_wv[%0d]: got %0b want 0", i, win_valid); end
      end
      feed(16);
      total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL prime_wv: got %0b want 1", win_valid); end
      total++; if (fill_count !== 5'd16) begin bad++; $display("FAIL prime_fill: got %0d want 16", fill_count); end
      total++; if (slot(0) !== 12'd16) begin bad++; $display("FAIL prime_slot0: got %h want 010", slot(0)); end
      total++; if (slot(15) !== 12'd1) begin bad++; $display("FAIL prime_slot15: got %h want 001", slot(15)); end
      idle();
      total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL prime_single_strobe: got %0b want 0", win_valid); end
      feed(17);
      total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL run_wv: got %0b want 1", win_valid); end
      total++; if (slot(0) !== 12'd17) begin bad++; $display("FAIL run_slot0: got %h want 011", slot(0)); end
      total++; if (slot(15) !== 12'd2) begin bad++; $display("FAIL run_slot15: got %h want 002", slot(15)); end
      feed(-5);
      total++; if (slot(0) !== 12'hFFB) begin bad++; $display("FAIL neg_slot0: got %h want ffb", slot(0)); end
      total++; if (slot(1) !== 12'd17) begin bad++; $display("FAIL neg_slot1: got %h want 011", slot(1)); end
   endtask

   task automatic test_gaps();
      logic [N*IW-1:0] hold;
      hold = win_samples;
      for (int i = 0; i < 3; i++) begin
         idle();
         total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL gap_wv[%0d]: got %0b want 0", i, win_valid); end
         total++; if (win_samples !== hold) begin bad++; $display("FAIL gap_samples[%0d]: got %h want %h", i, win_samples, hold); end
         total++; if (fill_count !== 5'd16) begin bad++; $display("FAIL gap_fill[%0d]: got %0d want 16", i, fill_count); end
      end
   endtask

   task automatic test_coef_load();
      for (int k = 0; k < 15; k++) begin
         coef_wr_en = 1'b1; coef_wr_addr = 4'(k); coef_wr_data = CWD'(k + 1);
         idle();
      end
      coef_wr_addr = 4'd15; coef_wr_data = 16'd16; coef_commit = 1'b1;
      idle();
      coef_wr_en = 1'b0; coef_commit = 1'b0;
      total++; if (coef_busy !== 1'b1) begin bad++; $display("FAIL load_busy_set: got %0b want 1", coef_busy); end
      total++; if (coeff(0) !== 16'd0) begin bad++; $display("FAIL load_not_yet: got %h want 0000", coeff(0)); end
      coef_wr_en = 1'b1; coef_wr_addr = 4'd0; coef_wr_data = 16'h7777;
      idle();
      coef_wr_en = 1'b0;
      total++; if (coef_busy !== 1'b0) begin bad++; $display("FAIL load_busy_clr: got %0b want 0", coef_busy); end
      total++; if (coeff(0) !== 16'd1) begin bad++; $display("FAIL load_coeff0: got %h want 0001", coeff(0)); end
      total++; if (coeff(15) !== 16'd16) begin bad++; $display("FAIL load_coeff15: got %h want 0010", coeff(15)); end
      total++; if (coeff(7) !== 16'd8) begin bad++; $display("FAIL load_coeff7: got %h want 0008", coeff(7)); end
      coef_commit = 1'b1;
      idle();
      coef_commit = 1'b0;
      idle();
      total++; if (coeff(0) !== 16'd1) begin bad++; $display("FAIL busy_write_dropped: got %h want 0001", coeff(0)); end
   endtask

   task automatic test_commit_stream();
      coef_wr_en = 1'b1; coef_wr_addr = 4'd0; coef_wr_data = 16'd100;
      idle();
      coef_wr_en = 1'b0;
      coef_commit = 1'b1;
      feed(200);
      coef_commit = 1'b0;
      total++; if (coef_busy !== 1'b1) begin bad++; $display("FAIL stream_busy_set: got %0b want 1", coef_busy); end
      for (int i = 0; i < 20; i++) begin
         feed(201 + i);
         total++; if (coef_busy !== 1'b1) begin bad++; $display("FAIL stream_busy[%0d]: got %0b want 1", i, coef_busy); end
         total++; if (coeff(0) !== 16'd1) begin bad++; $display("FAIL stream_coeff0[%0d]: got %h want 0001", i, coeff(0)); end
         total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL stream_wv[%0d]: got %0b want 1", i, win_valid); end
      end
      idle();
      total++; if (coef_busy !== 1'b0) begin bad++; $display("FAIL stream_busy_clr: got %0b want 0", coef_busy); end
      total++; if (coeff(0) !== 16'd100) begin bad++; $display("FAIL stream_swap: got %h want 0064", coeff(0)); end
      total++; if (coeff(1) !== 16'd2) begin bad++; $display("FAIL stream_coeff1: got %h want 0002", coeff(1)); end
   endtask

   task automatic test_flush();
      s_valid = 1'b1; s_data = 12'd55; flush = 1'b1;
      #1;
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL flush_s_ready: got %0b want 0", s_ready); end
      @(posedge clk);
      #1;
      flush = 1'b0; s_valid = 1'b0;
      total++; if (win_samples !== '0) begin bad++; $display("FAIL flush_samples: got %h want 0", win_samples); end
      total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL flush_fill: got %0d want 0", fill_count); end
      total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL flush_wv: got %0b want 0", win_valid); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL flush_state_ready: got %0b want 0", s_ready); end
      total++; if (coeff(0) !== 16'd100) begin bad++; $display("FAIL flush_bank_kept: got %h want 0064", coeff(0)); end
      idle();
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL refill_ready: got %0b want 1", s_ready); end
      for (int i = 0; i < 15; i++) begin
         feed(31 + i);
         total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL refill_early_wv[%0d]: got %0b want 0", i, win_valid); end
      end
      feed(46);
      total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL refill_wv: got %0b want 1", win_valid); end
      total++; if (slot(15) !== 12'd31) begin bad++; $display("FAIL refill_slot15: got %h want 01f", slot(15)); end
      total++; if (slot(0) !== 12'd46) begin bad++; $display("FAIL refill_slot0: got %h want 02e", slot(0)); end
   endtask

   task automatic test_async_reset();
      s_valid = 1'b1; s_data = 12'd7; coef_commit = 1'b1;
      @(posedge clk);
      #1;
      coef_commit = 1'b0;
      total++; if (win_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_wv: got %0b want 1", win_valid); end
      total++; if (coef_busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy: got %0b want 1", coef_busy); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL async_wv: got %0b want 0", win_valid); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL async_s_ready: got %0b want 0", s_ready); end
      total++; if (coef_busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %0b want 0", coef_busy); end
      s_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      total++; if (win_samples !== '0) begin bad++; $display("FAIL post_rst_samples: got %h want 0", win_samples); end
      total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL post_rst_fill: got %0d want 0", fill_count); end
      total++; if (win_coeffs !== '0) begin bad++; $display("FAIL post_rst_coeffs: got %h want 0", win_coeffs); end
      feed(9);
      total++; if (slot(0) !== 12'd9) begin bad++; $display("FAIL first_accept_slot0: got %h want 009", slot(0)); end
      total++; if (fill_count !== 5'd1) begin bad++; $display("FAIL first_accept_fill: got %0d want 1", fill_count); end
      total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL first_accept_wv: got %0b want 0", win_valid); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      s_valid      = 1'b0;
      s_data       = '0;
      coef_wr_en   = 1'b0;
      coef_wr_addr = '0;
      coef_wr_data = '0;
      coef_commit  = 1'b0;
      flush        = 1'b0;
      test_reset();
      test_prime();
      test_gaps();
      test_coef_load();
      test_commit_stream();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
